// File: rtl/frame_asm_pkg.sv
// Shared types and helpers for the ping-pong frame assembler.
// No logic; state encoding, header sync constant and frame-length helper.
// Backpressure: n/a.
package frame_asm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    HDR,
    SND_RD,
    SND_WR,
    PRM_RD,
    PRM_WR,
    DONE
  } state_t;

  localparam logic [15:0] HDR_SYNC = 16'hA5A5;

  // Total words written per frame: optional header, sound block, flight block.
  function automatic int frame_len(input int header, input int samples, input int params);
    return header + samples + params;
  endfunction

endpackage

// File: rtl/pingpong_ctrl.sv
// Bank bookkeeping for the two-half frame RAM: pending flags, write/read bank pointers.
// Latency: flags update on the clock of DONE / tx_done; overrun is a registered 1-clock pulse.
// Backpressure: a new frame is refused (overrun) while both banks await the transmitter.
module pingpong_ctrl (
  input  logic clock,
  input  logic reset,
  input  logic start_req,
  input  logic frame_done,
  input  logic tx_done,
  output logic start_ok,
  output logic wbank,
  output logic rdy_valid,
  output logic rdy_bank,
  output logic overrun
);

  logic [1:0] pending;
  logic [1:0] pending_nxt;
  logic       rbank;
  logic       release_bank;

  assign rdy_valid    = |pending;
  assign rdy_bank     = rbank;
  assign release_bank = tx_done & rdy_valid;
  // A frame may only start while at least one half of the RAM is free.
  assign start_ok     = start_req & ~(&pending);

  // Clear the bank the transmitter released and mark the freshly written one;
  // in the same clock these always address different banks.
  always_comb begin
    pending_nxt = pending;
    if (release_bank) pending_nxt[rbank] = 1'b0;
    if (frame_done)   pending_nxt[wbank] = 1'b1;
  end

  // Flag, pointer and overrun registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= 2'b00;
      wbank   <= 1'b0;
      rbank   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (frame_done)   wbank <= ~wbank;
      if (release_bank) rbank <= ~rbank;
      overrun <= start_req & (&pending);
    end
  end

endmodule

// File: rtl/frame_assembler_mc.sv
// Builds one frame per msec tick (header, sound words, flight words) into a ping-pong RAM.
// Latency: 1 + HEADER + 2*SAMPLES + 2*PARAMS_PER_FRAME + 1 clocks from tick to bank ready.
// Backpressure: tx_done frees banks; a tick with both banks pending is dropped with overrun.
module frame_assembler_mc
  import frame_asm_pkg::*;
#(
  parameter int CH               = 2,
  parameter int SW               = 16,
  parameter int DW               = 32,
  parameter int SAMPLES          = 500,
  parameter int PARAMS_PER_FRAME = 12,
  parameter int PARAM_WRAP       = 48,
  parameter int HEADER           = 1,
  parameter int BANK_AW          = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               timer,
  input  logic               msec,
  output logic [8:0]         snd_addr,
  input  logic [CH*SW-1:0]   snd_data,
  output logic [7:0]         prm_addr,
  input  logic [DW-1:0]      prm_data,
  output logic               wr_en,
  output logic [BANK_AW:0]   wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic               rdy_valid,
  output logic               rdy_bank,
  input  logic               tx_done,
  output logic [7:0]         frame_cnt,
  output logic               overrun,
  output logic               busy
);

  localparam int FRAME_LEN = frame_len(HEADER, SAMPLES, PARAMS_PER_FRAME);
  localparam logic [BANK_AW-1:0] SND_LAST = BANK_AW'(HEADER + SAMPLES - 1);
  localparam logic [BANK_AW-1:0] PRM_LAST = BANK_AW'(FRAME_LEN - 1);

  if (CH * SW != DW) begin : g_bad_width
    $error("frame_assembler_mc: CH*SW must equal DW");
  end
  if (FRAME_LEN > (1 << BANK_AW)) begin : g_bad_bank
    $error("frame_assembler_mc: frame does not fit in one bank");
  end

  state_t             state;
  state_t             state_nxt;
  logic               msec_q;
  logic               tick;
  logic               start_req;
  logic               start_ok;
  logic               frame_done;
  logic               wbank;
  logic [BANK_AW-1:0] offset;
  logic [8:0]         prm_inc;
  logic [7:0]         prm_nxt;
  logic [DW-1:0]      hdr_word;

  assign tick       = msec & ~msec_q;
  assign start_req  = (state == WAIT_TICK) & tick;
  assign frame_done = (state == DONE);
  assign hdr_word   = DW'({HDR_SYNC, 8'h00, frame_cnt});
  assign prm_inc    = {1'b0, prm_addr} + 9'd1;
  assign prm_nxt    = (prm_inc >= 9'(PARAM_WRAP)) ? 8'd0 : prm_inc[7:0];
  assign wr_addr    = {wbank, offset};

  pingpong_ctrl u_pingpong (
    .clock      (clock),
    .reset      (reset),
    .start_req  (start_req),
    .frame_done (frame_done),
    .tx_done    (tx_done),
    .start_ok   (start_ok),
    .wbank      (wbank),
    .rdy_valid  (rdy_valid),
    .rdy_bank   (rdy_bank),
    .overrun    (overrun)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state sequencing and the frame RAM write port.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_data   = '0;
    case (state)
      IDLE:      if (timer) state_nxt = WAIT_TICK;
      WAIT_TICK: if (start_ok) state_nxt = (HEADER != 0) ? HDR : SND_RD;
      HDR: begin
        wr_en     = 1'b1;
        wr_data   = hdr_word;
        state_nxt = SND_RD;
      end
      SND_RD:    state_nxt = SND_WR;
      SND_WR: begin
        wr_en     = 1'b1;
        wr_data   = snd_data;
        state_nxt = (offset == SND_LAST) ? PRM_RD : SND_RD;
      end
      PRM_RD:    state_nxt = PRM_WR;
      PRM_WR: begin
        wr_en     = 1'b1;
        wr_data   = prm_data;
        state_nxt = (offset == PRM_LAST) ? DONE : PRM_RD;
      end
      DONE:      state_nxt = WAIT_TICK;
      default:   state_nxt = IDLE;
    endcase
  end

  // Address counters, frame counter and busy flag; flight address persists across frames.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      msec_q    <= 1'b0;
      offset    <= '0;
      snd_addr  <= '0;
      prm_addr  <= '0;
      frame_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      msec_q <= msec;
      case (state)
        WAIT_TICK: if (start_ok) begin
          busy     <= 1'b1;
          offset   <= '0;
          snd_addr <= '0;
        end
        HDR:    offset <= offset + 1'b1;
        SND_WR: begin
          offset   <= offset + 1'b1;
          snd_addr <= snd_addr + 1'b1;
        end
        PRM_WR: begin
          offset   <= offset + 1'b1;
          prm_addr <= prm_nxt;
        end
        DONE: begin
          frame_cnt <= frame_cnt + 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_assembler_mc.sv
// Scoreboard bench for frame_assembler_mc: default instance plus a short-frame instance.
// Expected writes are queued when a tick is issued; monitors pop them on every wr_en.
// Bank handshake, overrun and reset behaviour are checked with directed sequences.
module tb_frame_assembler_mc;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, timer, msec, tx_done;
  logic [8:0]  snd_addr;
  logic [31:0] snd_data, prm_data, wr_data;
  logic [7:0]  prm_addr, frame_cnt;
  logic        wr_en, rdy_valid, rdy_bank, overrun, busy;
  logic [10:0] wr_addr;

  logic        s_msec, s_tx_done;
  logic [8:0]  s_snd_addr;
  logic [31:0] s_snd_data, s_prm_data, s_wr_data;
  logic [7:0]  s_prm_addr, s_frame_cnt;
  logic        s_wr_en, s_rdy_valid, s_rdy_bank, s_overrun, s_busy;
  logic [10:0] s_wr_addr;

  frame_assembler_mc dut (
    .clock(clock), .reset(reset), .timer(timer), .msec(msec),
    .snd_addr(snd_addr), .snd_data(snd_data), .prm_addr(prm_addr), .prm_data(prm_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rdy_valid(rdy_valid), .rdy_bank(rdy_bank), .tx_done(tx_done),
    .frame_cnt(frame_cnt), .overrun(overrun), .busy(busy)
  );

  frame_assembler_mc #(.HEADER(0), .SAMPLES(4), .PARAMS_PER_FRAME(2)) dut_s (
    .clock(clock), .reset(reset), .timer(timer), .msec(s_msec),
    .snd_addr(s_snd_addr), .snd_data(s_snd_data), .prm_addr(s_prm_addr), .prm_data(s_prm_data),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rdy_valid(s_rdy_valid), .rdy_bank(s_rdy_bank), .tx_done(s_tx_done),
    .frame_cnt(s_frame_cnt), .overrun(s_overrun), .busy(s_busy)
  );

  // Sound store and flight table: registered reads, data one clock after address.
  always @(posedge clock) begin
    snd_data   <= 32'h0001_0000 + {23'd0, snd_addr};
    prm_data   <= 32'hF000_0000 + {24'd0, prm_addr};
    s_snd_data <= 32'h0001_0000 + {23'd0, s_snd_addr};
    s_prm_data <= 32'hF000_0000 + {24'd0, s_prm_addr};
  end

  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t s_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  ovr_cnt = 0;
  int  cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitors: every write must match the head of its scoreboard queue.
  always @(negedge clock) begin
    wr_t e;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("write", {21'd0, wr_addr, wr_data}, {21'd0, e.addr, e.data});
      end
    end
    if (overrun) ovr_cnt++;
  end

  always @(negedge clock) begin
    wr_t e;
    if (s_wr_en) begin
      if (s_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL small_unexpected_write: got addr %0h data %0h, required no write", s_wr_addr, s_wr_data);
      end else begin
        e = s_q.pop_front();
        check("small_write", {21'd0, s_wr_addr, s_wr_data}, {21'd0, e.addr, e.data});
      end
    end
  end

  task automatic push_w(input bit sm, input int bank, input int off, input logic [31:0] d);
    wr_t w;
    w.addr = 11'(bank * 1024 + off);
    w.data = d;
    if (sm) s_q.push_back(w);
    else    exp_q.push_back(w);
  endtask

  task automatic push_frame(input bit sm, input int bank, input int fcnt, input int pbase,
                            input int hdr, input int ns, input int np);
    int off = 0;
    if (hdr != 0) begin
      push_w(sm, bank, off, {16'hA5A5, 8'h00, 8'(fcnt)});
      off++;
    end
    for (int i = 0; i < ns; i++) begin
      push_w(sm, bank, off, 32'h0001_0000 + 32'(i));
      off++;
    end
    for (int j = 0; j < np; j++) begin
      push_w(sm, bank, off, 32'hF000_0000 + 32'((pbase + j) % 48));
      off++;
    end
  endtask

  // Raise msec, count clocks until frame_cnt reaches target; optional tx_done at clock txd_at.
  task automatic run_frame(input bit sm, input int target, input int txd_at, output int n);
    bit reached = 0;
    n = 0;
    @(negedge clock);
    if (sm) s_msec = 1'b1;
    else    msec   = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      msec   = 1'b0;
      s_msec = 1'b0;
      n++;
      tx_done = (n == txd_at);
      if ((sm ? s_frame_cnt : frame_cnt) == 8'(target)) begin
        reached = 1;
        break;
      end
    end
    tx_done = 1'b0;
    if (!reached) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_timeout: got frame_cnt %0d, required %0d", sm ? s_frame_cnt : frame_cnt, target);
    end
  endtask

  task automatic tick_only();
    @(negedge clock) msec = 1'b1;
    @(negedge clock) msec = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic pulse_tx();
    @(negedge clock) tx_done = 1'b1;
    @(negedge clock) tx_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock) reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_outs"}, {16'd0, wr_en, wr_addr, wr_data, rdy_valid, rdy_bank, overrun, busy}, 64'd0);
    check({tag, "_cnts"}, {39'd0, frame_cnt, snd_addr, prm_addr}, 64'd0);
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; timer = 1'b0; msec = 1'b0; tx_done = 1'b0;
    s_msec = 1'b0; s_tx_done = 1'b0;
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Tick before the start gate opens must be ignored.
    tick_only();
    check("idle_gate", {55'd0, busy, frame_cnt}, 64'd0);

    timer = 1'b1;
    repeat (2) @(negedge clock);

    // Short-frame instance: no header, 4 sound + 2 flight words, 14 clocks.
    push_frame(1, 0, 0, 0, 0, 4, 2);
    run_frame(1, 1, 0, cyc);
    check("small_clocks", cyc, 14);
    check("small_queue_drained", s_q.size(), 0);
    check("small_rdy", {s_rdy_valid, s_rdy_bank}, 2'b10);

    // Single default frame into bank 0.
    push_frame(0, 0, 0, 0, 1, 500, 12);
    run_frame(0, 1, 0, cyc);
    check("frame_clocks", cyc, 1027);
    check("queue_drained", exp_q.size(), 0);
    check("rdy_after_f1", {rdy_valid, rdy_bank}, 2'b10);
    check("frame_cnt_f1", frame_cnt, 1);
    check("prm_addr_f1", prm_addr, 12);
    check("busy_f1", busy, 0);

    // Four frames with tx_done: banks alternate, flight address wraps after 48.
    do_reset();
    for (int f = 0; f < 4; f++) begin
      push_frame(0, f % 2, f, f * 12, 1, 500, 12);
      run_frame(0, f + 1, 0, cyc);
      check("alt_bank", rdy_bank, f % 2);
      check("alt_queue", exp_q.size(), 0);
      pulse_tx();
      check("alt_released", rdy_valid, 0);
    end
    check("prm_wrap", prm_addr, 0);

    // Both banks pending: third tick is dropped with one overrun pulse.
    do_reset();
    ovr_cnt = 0;
    push_frame(0, 0, 0, 0, 1, 500, 12);
    run_frame(0, 1, 0, cyc);
    push_frame(0, 1, 1, 12, 1, 500, 12);
    run_frame(0, 2, 0, cyc);
    check("full_rdy", {rdy_valid, rdy_bank}, 2'b10);
    tick_only();
    check("overrun_pulses", ovr_cnt, 1);
    check("overrun_frame_cnt", frame_cnt, 2);
    check("overrun_busy", busy, 0);
    pulse_tx();
    check("full_after_tx", {rdy_valid, rdy_bank}, 2'b11);

    // tx_done coincident with DONE of the second frame.
    do_reset();
    push_frame(0, 0, 0, 0, 1, 500, 12);
    run_frame(0, 1, 0, cyc);
    push_frame(0, 1, 1, 12, 1, 500, 12);
    run_frame(0, 2, 1026, cyc);
    check("coinc_rdy", {rdy_valid, rdy_bank}, 2'b11);
    pulse_tx();
    check("coinc_only_one", rdy_valid, 0);

    // Reset in the middle of the sound block abandons the partial bank.
    do_reset();
    push_frame(0, 0, 0, 0, 1, 500, 12);
    @(negedge clock) msec = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clock) msec = 1'b0;
      if (snd_addr == 9'd200) break;
    end
    check("mid_reached", snd_addr, 200);
    #2 reset = 1'b0;
    #1 check_zero("mid_reset");
    exp_q.delete();
    repeat (3) @(negedge clock);
    check_zero("mid_reset_hold");
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("mid_no_pending", rdy_valid, 0);
    push_frame(0, 0, 0, 0, 1, 500, 12);
    run_frame(0, 1, 0, cyc);
    check("mid_refill_clocks", cyc, 1027);
    check("mid_refill_queue", exp_q.size(), 0);
    check("mid_refill_rdy", {rdy_valid, rdy_bank}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
